// File: rtl/fir_tdm_mc_pkg.sv
// Shared types and default geometry for the time-multiplexed multi-channel FIR.
// Index-width helper keeps single-entry dimensions at one bit.
package fir_tdm_pkg;

  typedef enum logic [1:0] {IDLE, MAC, RND} state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_COEF_WIDTH  = 15;
  localparam int DEF_NUM_TAPS    = 16;
  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_ACCUM_WIDTH = 38;
  localparam int DEF_LSB_RM      = 22;
  localparam int DEF_OUT_WIDTH   = 16;

  localparam int DEF_PTR_W = idx_w(DEF_NUM_TAPS);
  localparam int DEF_TAP_W = idx_w(DEF_NUM_TAPS);
  localparam int DEF_CH_W  = idx_w(DEF_NUM_CH);

endpackage

// File: rtl/fir_tdm_mc_if.sv
// Sample load / coefficient write / result bundle of the TDM FIR.
// master = upstream+downstream side, slave = filter.
interface fir_tdm_mc_if import fir_tdm_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
);
  logic signed [DATA_WIDTH-1:0]   data_in;
  logic                           ld;
  logic                           coef_we;
  logic [idx_w(NUM_TAPS)-1:0]     coef_addr;
  logic signed [COEF_WIDTH-1:0]   coef_data;
  logic                           rdy_to_ld;
  logic signed [OUT_WIDTH-1:0]    fir_result;
  logic [idx_w(NUM_CH)-1:0]       res_ch;
  logic                           done;
  logic                           sat;

  modport master (
    output data_in, ld, coef_we, coef_addr, coef_data,
    input  rdy_to_ld, fir_result, res_ch, done, sat
  );

  modport slave (
    input  data_in, ld, coef_we, coef_addr, coef_data,
    output rdy_to_ld, fir_result, res_ch, done, sat
  );
endinterface

// File: rtl/fir_rnd_sat.sv
// Combinational round-half-up by LSB_RM bits followed by signed saturation to OUT_WIDTH.
// One guard bit keeps the rounding add from wrapping at the top of the accumulator range.
module fir_rnd_sat #(
  parameter int ACCUM_WIDTH = 38,
  parameter int LSB_RM      = 22,
  parameter int OUT_WIDTH   = 16
) (
  input  logic signed [ACCUM_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0]   r,
  output logic                          sat
);
  localparam int EW = ACCUM_WIDTH + 1;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  logic signed [EW-1:0] acc_ext;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] shifted;

  assign acc_ext = {acc[ACCUM_WIDTH-1], acc};

  generate
    if (LSB_RM == 0) begin : g_no_rnd
      assign sum = acc_ext;
    end else begin : g_rnd
      localparam logic signed [EW-1:0] HALF = EW'(1) << (LSB_RM - 1);
      assign sum = acc_ext + HALF;
    end
  endgenerate

  assign shifted = sum >>> LSB_RM;

  always_comb begin
    r   = shifted[OUT_WIDTH-1:0];
    sat = 1'b0;
    if (shifted > MAX_V) begin
      r   = MAX_V[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      r   = MIN_V[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/fir_tdm_mc.sv
// Single-MAC FIR shared by NUM_CH round-robin channels, runtime coefficients, rounded+saturated output.
// Latency NUM_TAPS+2 enabled cycles; rdy_to_ld low while busy, clk_en low freezes all state.
module fir_tdm_mc import fir_tdm_pkg::*; #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COEF_WIDTH  = DEF_COEF_WIDTH,
  parameter int NUM_TAPS    = DEF_NUM_TAPS,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
  parameter int LSB_RM      = DEF_LSB_RM,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
  input logic          clk,
  input logic          rst,
  input logic          clk_en,
  fir_tdm_mc_if.slave  bus
);
  localparam int TAP_W  = idx_w(NUM_TAPS);
  localparam int CH_W   = idx_w(NUM_CH);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

  state_t                        state_q, state_d;
  logic [CH_W-1:0]               ch_q, ch_d, res_ch_q, res_ch_d;
  logic [TAP_W-1:0]              ptr_q, ptr_d, k_q, k_d, tap_idx;
  logic signed [ACCUM_WIDTH-1:0] acc_q, acc_d, prod_ext;
  logic signed [PROD_W-1:0]      prod;
  logic signed [DATA_WIDTH-1:0]  dline_q [NUM_CH][NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  dline_d [NUM_CH][NUM_TAPS];
  logic signed [COEF_WIDTH-1:0]  coef_q [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0]  coef_d [NUM_TAPS];
  logic signed [OUT_WIDTH-1:0]   fir_result_q, fir_result_d, rnd_r;
  logic                          done_q, done_d, sat_q, sat_d, rnd_sat, accept;

  fir_rnd_sat #(
    .ACCUM_WIDTH (ACCUM_WIDTH),
    .LSB_RM      (LSB_RM),
    .OUT_WIDTH   (OUT_WIDTH)
  ) u_rnd_sat (
    .acc (acc_q),
    .r   (rnd_r),
    .sat (rnd_sat)
  );

  // Delay line is circular: newest sample at ptr, tap k reads ptr-k modulo NUM_TAPS.
  assign tap_idx  = ptr_q - k_q;
  assign prod     = PROD_W'(coef_q[k_q]) * PROD_W'(dline_q[ch_q][tap_idx]);
  assign prod_ext = {{(ACCUM_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
  assign accept   = (state_q == IDLE) && bus.ld;

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    ptr_d        = ptr_q;
    k_d          = k_q;
    acc_d        = acc_q;
    dline_d      = dline_q;
    coef_d       = coef_q;
    fir_result_d = fir_result_q;
    res_ch_d     = res_ch_q;
    sat_d        = sat_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dline_d[ch_q][ptr_q] = bus.data_in;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end else if (bus.coef_we) begin
          coef_d[bus.coef_addr] = bus.coef_data;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + TAP_W'(1);
        if (k_q == TAP_W'(NUM_TAPS - 1)) state_d = RND;
      end
      RND: begin
        fir_result_d = rnd_r;
        sat_d        = rnd_sat;
        res_ch_d     = ch_q;
        done_d       = 1'b1;
        state_d      = IDLE;
        // The write slot only advances once every channel has consumed it.
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_d  = '0;
          ptr_d = ptr_q + TAP_W'(1);
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      ptr_q        <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      dline_q      <= '{default: '0};
      coef_q       <= '{default: '0};
      fir_result_q <= '0;
      res_ch_q     <= '0;
      sat_q        <= 1'b0;
      done_q       <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      ptr_q        <= ptr_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      dline_q      <= dline_d;
      coef_q       <= coef_d;
      fir_result_q <= fir_result_d;
      res_ch_q     <= res_ch_d;
      sat_q        <= sat_d;
      done_q       <= done_d;
    end
  end

  assign bus.rdy_to_ld  = (state_q == IDLE);
  assign bus.fir_result = fir_result_q;
  assign bus.res_ch     = res_ch_q;
  assign bus.done       = done_q;
  assign bus.sat        = sat_q;
endmodule

// File: tb/tb_fir_tdm_mc.sv
// Scoreboard bench for fir_tdm_mc: dut0 with LSB_RM=0, dut1 with LSB_RM=1, 16 taps, 2 channels.
`timescale 1ns/1ps
module tb_fir_tdm_mc;
  typedef struct packed {
    logic               ch;
    logic signed [15:0] val;
    logic               sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  bit   gate = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  fir_tdm_mc_if #(.DATA_WIDTH(16), .COEF_WIDTH(15), .NUM_TAPS(16), .NUM_CH(2), .OUT_WIDTH(16)) bus0 ();
  fir_tdm_mc_if #(.DATA_WIDTH(16), .COEF_WIDTH(15), .NUM_TAPS(16), .NUM_CH(2), .OUT_WIDTH(16)) bus1 ();

  fir_tdm_mc #(.DATA_WIDTH(16), .COEF_WIDTH(15), .NUM_TAPS(16), .NUM_CH(2),
               .ACCUM_WIDTH(38), .LSB_RM(0), .OUT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus0));

  fir_tdm_mc #(.DATA_WIDTH(16), .COEF_WIDTH(15), .NUM_TAPS(16), .NUM_CH(2),
               .ACCUM_WIDTH(38), .LSB_RM(1), .OUT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus1));

  function automatic exp_t mk(input int c, input int v, input int s);
    exp_t e;
    e.ch  = c[0];
    e.val = v[15:0];
    e.sat = s[0];
    return e;
  endfunction

  // Result scoreboards: a done counts on each enabled edge it is high.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && clk_en && bus0.done) begin
      tests_run++;
      if (q0.size() == 0) begin
        tests_failed++;
        $display("FAIL dut0_unexpected_done got ch=%0d val=%0d, required no result", bus0.res_ch, bus0.fir_result);
      end else begin
        e = q0.pop_front();
        if ({bus0.res_ch, bus0.fir_result, bus0.sat} !== {e.ch, e.val, e.sat}) begin
          tests_failed++;
          $display("FAIL dut0_result got ch=%0d val=%0d sat=%0d, required ch=%0d val=%0d sat=%0d",
                   bus0.res_ch, bus0.fir_result, bus0.sat, e.ch, $signed(e.val), e.sat);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && clk_en && bus1.done) begin
      tests_run++;
      if (q1.size() == 0) begin
        tests_failed++;
        $display("FAIL dut1_unexpected_done got ch=%0d val=%0d, required no result", bus1.res_ch, bus1.fir_result);
      end else begin
        e = q1.pop_front();
        if ({bus1.res_ch, bus1.fir_result, bus1.sat} !== {e.ch, e.val, e.sat}) begin
          tests_failed++;
          $display("FAIL dut1_result got ch=%0d val=%0d sat=%0d, required ch=%0d val=%0d sat=%0d",
                   bus1.res_ch, bus1.fir_result, bus1.sat, e.ch, $signed(e.val), e.sat);
        end
      end
    end
  end

  // done must survive a disabled edge untouched.
  logic pd = 1'b0, pe = 1'b1, pr = 1'b1;
  always @(negedge clk) begin
    if (pd && !pe && !pr) begin
      tests_run++;
      if (bus0.done !== 1'b1) begin
        tests_failed++;
        $display("FAIL done_hold got done=%b across stall, required 1", bus0.done);
      end
    end
    pd = bus0.done;
    pe = clk_en;
    pr = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (gate) clk_en = ~clk_en;
    else      clk_en = 1'b1;
  endtask

  task automatic do_reset();
    bus0.ld = 1'b0; bus0.coef_we = 1'b0;
    bus1.ld = 1'b0; bus1.coef_we = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wcoef(input bit r, input int a, input int v);
    if (r) begin bus1.coef_we = 1'b1; bus1.coef_addr = a[3:0]; bus1.coef_data = v[14:0]; end
    else   begin bus0.coef_we = 1'b1; bus0.coef_addr = a[3:0]; bus0.coef_data = v[14:0]; end
    tick();
    bus0.coef_we = 1'b0;
    bus1.coef_we = 1'b0;
  endtask

  task automatic ramp();
    for (int k = 0; k < 16; k++) wcoef(1'b0, k, k + 1);
  endtask

  task automatic load(input bit r, input int d, input exp_t e, input bit push);
    int n = 0;
    bit acc = 1'b0;
    if (r) begin bus1.data_in = d[15:0]; bus1.ld = 1'b1; end
    else   begin bus0.data_in = d[15:0]; bus0.ld = 1'b1; end
    while (!acc && n < 200) begin
      acc = (r ? bus1.rdy_to_ld : bus0.rdy_to_ld) && clk_en;
      if (acc && push) begin
        if (r) q1.push_back(e);
        else   q0.push_back(e);
      end
      tick();
      n++;
    end
    bus0.ld = 1'b0;
    bus1.ld = 1'b0;
    tests_run++;
    if (!acc) begin
      tests_failed++;
      $display("FAIL load_timeout got accepted=%b, required 1", acc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    tests_run++;
    if (q0.size() != 0 || q1.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout got pending=%0d, required 0", q0.size() + q1.size());
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bus0.rdy_to_ld, bus0.done, bus0.sat, bus0.res_ch, bus0.fir_result} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'sd0}) begin
      tests_failed++;
      $display("FAIL reset_dut0 got rdy=%b done=%b sat=%b ch=%0d res=%0d, required 1 0 0 0 0",
               bus0.rdy_to_ld, bus0.done, bus0.sat, bus0.res_ch, bus0.fir_result);
    end
    tests_run++;
    if ({bus1.rdy_to_ld, bus1.done, bus1.sat, bus1.res_ch, bus1.fir_result} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'sd0}) begin
      tests_failed++;
      $display("FAIL reset_dut1 got rdy=%b done=%b sat=%b ch=%0d res=%0d, required 1 0 0 0 0",
               bus1.rdy_to_ld, bus1.done, bus1.sat, bus1.res_ch, bus1.fir_result);
    end
  endtask

  task automatic test_impulse();
    do_reset();
    ramp();
    for (int n = 0; n < 17; n++) begin
      load(1'b0, (n == 0) ? 1 : 0, mk(0, (n < 16) ? n + 1 : 0, 0), 1'b1);
      load(1'b0, 0, mk(1, 0, 0), 1'b1);
    end
    drain();
  endtask

  task automatic test_handshake();
    int acc_n = 0, last_done = -1, low_run = 0, dn = 0;
    do_reset();
    bus0.data_in = '0;
    for (int c = 0; c < 6 * 18 + 40; c++) begin
      if (bus0.done) begin
        dn++;
        if (last_done >= 0) begin
          tests_run++;
          if (c - last_done != 18) begin
            tests_failed++;
            $display("FAIL done_spacing got %0d cycles, required 18", c - last_done);
          end
        end
        last_done = c;
      end
      if (!bus0.rdy_to_ld) low_run++;
      else begin
        if (low_run > 0) begin
          tests_run++;
          if (low_run != 17) begin
            tests_failed++;
            $display("FAIL rdy_low_run got %0d cycles, required 17", low_run);
          end
        end
        low_run = 0;
      end
      bus0.ld = (acc_n < 6);
      if (bus0.rdy_to_ld && bus0.ld) begin
        q0.push_back(mk(acc_n % 2, 0, 0));
        acc_n++;
      end
      tick();
    end
    bus0.ld = 1'b0;
    tests_run++;
    if (dn != 6) begin
      tests_failed++;
      $display("FAIL done_count got %0d, required 6", dn);
    end
    drain();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(1'b0, k, 16383);
    load(1'b0, 32767, mk(0, 32767, 1), 1'b1);
    load(1'b0, 32767, mk(1, 32767, 1), 1'b1);
    drain();
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(1'b0, k, 16383);
    load(1'b0, -32768, mk(0, -32768, 1), 1'b1);
    load(1'b0, -32768, mk(1, -32768, 1), 1'b1);
    drain();
  endtask

  task automatic test_rounding();
    do_reset();
    wcoef(1'b1, 0, 3);
    load(1'b1, 1, mk(0, 2, 0), 1'b1);
    load(1'b1, -1, mk(1, -1, 0), 1'b1);
    drain();
  endtask

  task automatic test_coef_guard();
    do_reset();
    ramp();
    bus0.coef_we = 1'b1; bus0.coef_addr = 4'd0; bus0.coef_data = 15'sd5;
    load(1'b0, 0, mk(0, 0, 0), 1'b1);
    repeat (6) tick();
    bus0.coef_we = 1'b0;
    load(1'b0, 1, mk(1, 1, 0), 1'b1);
    drain();
    wcoef(1'b0, 0, 5);
    load(1'b0, 1, mk(0, 5, 0), 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    ramp();
    load(1'b0, 0, mk(0, 0, 0), 1'b1);
    load(1'b0, 3, mk(1, 3, 0), 1'b1);
    drain();
    load(1'b0, 1, mk(0, 0, 0), 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({bus0.rdy_to_ld, bus0.done, bus0.sat, bus0.res_ch, bus0.fir_result} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'sd0}) begin
      tests_failed++;
      $display("FAIL midmac_reset_outputs got rdy=%b done=%b sat=%b ch=%0d res=%0d, required 1 0 0 0 0",
               bus0.rdy_to_ld, bus0.done, bus0.sat, bus0.res_ch, bus0.fir_result);
    end
    for (int c = 0; c < 20; c++) begin
      if (bus0.done) seen = 1'b1;
      tick();
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL midmac_no_done got done seen=%b, required 0", seen);
    end
    ramp();
    load(1'b0, 1, mk(0, 1, 0), 1'b1);
    load(1'b0, 0, mk(1, 0, 0), 1'b1);
    load(1'b0, 0, mk(0, 2, 0), 1'b1);
    load(1'b0, 0, mk(1, 0, 0), 1'b1);
    load(1'b0, 0, mk(0, 3, 0), 1'b1);
    drain();
  endtask

  task automatic test_clk_en();
    int x0[4] = '{1, 0, 0, 0};
    int x1[4] = '{0, 3, 0, 0};
    int y0[4] = '{1, 2, 3, 4};
    int y1[4] = '{0, 3, 6, 9};
    do_reset();
    ramp();
    gate = 1'b1;
    for (int n = 0; n < 4; n++) begin
      load(1'b0, x0[n], mk(0, y0[n], 0), 1'b1);
      load(1'b0, x1[n], mk(1, y1[n], 0), 1'b1);
    end
    drain();
    gate = 1'b0;
    tick();
  endtask

  initial begin
    bus0.ld = 1'b0; bus0.coef_we = 1'b0; bus0.data_in = '0; bus0.coef_addr = '0; bus0.coef_data = '0;
    bus1.ld = 1'b0; bus1.coef_we = 1'b0; bus1.data_in = '0; bus1.coef_addr = '0; bus1.coef_data = '0;
    test_reset();
    test_impulse();
    test_handshake();
    test_saturation();
    test_rounding();
    test_coef_guard();
    test_reset_mid();
    test_clk_en();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout got no finish, required finish within 1ms");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_tdm_mc.md
# fir_tdm_mc

Parametrised, time-multiplexed, multi-channel FIR filter that generalises the team's fixed two-slice lowpass: one signed multiply-accumulate unit serves NUM_CH interleaved channels, each with its own NUM_TAPS-deep delay line. Coefficients are runtime-loadable, and the output gets round-half-up plus signed saturation instead of bare truncation of the top bits. The block sits in the acquisition datapath between the ADC sample formatter and the decimation/FFT stages. It keeps the existing `rdy_to_ld` / `done` handshake so upstream and downstream logic are unchanged.

## Interface
- DATA_WIDTH, 16: signed input sample width.
- COEF_WIDTH, 15: signed coefficient width.
- NUM_TAPS, 16: taps per channel, ≥2, power of two.
- NUM_CH, 2: interleaved channels, ≥1.
- ACCUM_WIDTH, 38: accumulator width, ≥ DATA_WIDTH+COEF_WIDTH+clog2(NUM_TAPS).
- LSB_RM, 22: LSBs removed by rounding, ≥0.
- OUT_WIDTH, 16: saturated output width.
- clk  in  1  sole clock; one clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clk_en  in  1  global enable; when low, every register holds.
- data_in  in  DATA_WIDTH  signed sample for the current channel.
- ld  in  1  sample valid; accepted when ld & rdy_to_ld & clk_en.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(NUM_TAPS)  coefficient index k.
- coef_data  in  COEF_WIDTH  signed coefficient h[k].
- rdy_to_ld  out  1  high in IDLE; reset value 1 (first cycle after rst).
- fir_result  out  OUT_WIDTH  signed filtered sample; reset 0.
- res_ch  out  clog2(NUM_CH) (min 1)  channel of fir_result; reset 0.
- done  out  1  result-valid pulse, one enabled cycle; reset 0.
- sat  out  1  fir_result was clipped; valid with done; reset 0.

## Operation
- FSM states: IDLE, MAC, RND. Reset → IDLE. All listed transitions happen only on clk_en=1.
- IDLE: on accept, write data_in to delay line of channel `ch` at slot `ptr`, clear acc, set k=0, go to MAC.
- MAC: acc += h[k] * x[ch][(ptr−k) mod NUM_TAPS]. The product is sign-extended to ACCUM_WIDTH and acc wraps at ACCUM_WIDTH. k increments. After k = NUM_TAPS−1, go to RND.
- RND: r = (acc + 2^(LSB_RM−1)) >>> LSB_RM, arithmetic shift; with LSB_RM=0 there is no add. r is clipped to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. Register fir_result, res_ch=ch, sat. Assert done for the next cycle. Advance ch. When ch wraps from NUM_CH−1 to 0, ptr = (ptr+1) mod NUM_TAPS. Return to IDLE.
- Channel order is fixed: 0,1,…,NUM_CH−1,0,… There is no channel tag on input.
- Coefficient writes take effect only in IDLE and only when no load is accepted in the same cycle. A write in MAC or RND, or coincident with an accepted load, is dropped silently. Coefficients are shared by all channels.
- ld is ignored outside IDLE (rdy_to_ld=0).
- Reset at any point (mid-MAC included) does the following:
  - aborts the computation, with no done;
  - zeroes all delay lines, coefficients, acc, ptr and ch;
  - returns to IDLE.

## Timing
- Accept at enabled cycle L. MAC occupies cycles L+1 … L+NUM_TAPS. RND is cycle L+NUM_TAPS+1. done, fir_result and sat are visible in cycle L+NUM_TAPS+2. In that cycle the FSM is already in IDLE with rdy_to_ld=1.
- Latency is NUM_TAPS+2 enabled cycles. Maximum throughput is one sample per NUM_TAPS+2 enabled cycles. A new load is allowed in the cycle done is high.
- clk_en low stretches every interval; done stays high until the next enabled edge.
- fir_result and res_ch hold their value until the next RND.

## Structure
- Package fir_tdm_pkg holds the following:
  - state enum {IDLE, MAC, RND};
  - localparams for pointer, tap and channel index widths;
  - the default-width constants.
- Sub-module fir_rnd_sat holds the combinational round-half-up and saturate logic (ACCUM_WIDTH, LSB_RM, OUT_WIDTH → r, sat). It is reused by later decimators.
- Delay lines are a register array [NUM_CH][NUM_TAPS] with combinational read.

## Test plan
Bench parameters: NUM_TAPS=16, NUM_CH=2, LSB_RM=0, OUT_WIDTH=16 unless stated.
- Impulse: h[k]=k+1. Feed ch0: 1 then 0s; ch1: all 0s. Required: ch0 results 1,2,…,16 then 0; every ch1 result is 0, proving channel isolation.
- Latency/handshake: hold ld high continuously. Required:
  - done spacing is exactly 18 cycles;
  - rdy_to_ld is low for 17 cycles after each accept;
  - res_ch alternates 0,1.
- Saturation: all h=16383, all samples 32767. Required: fir_result=32767, sat=1. With all samples −32768, required: −32768, sat=1.
- Rounding: LSB_RM=1, h[0]=3, other taps 0, input 1. Required: 2. With input −1, required: −1, sat=0.
- Coef write guard: write h[0]=5 during MAC. Required: dropped, so the next impulse response still starts at 1. The same write in IDLE takes effect, so the response starts at 5.
- Reset mid-MAC plus clk_en gaps:
  - Assert rst at MAC k=7. Required: no done; all outputs return to reset values; the next impulse gives the pristine 1,2,…; ch restarts at 0.
  - Toggle clk_en 50%. Required: the result is identical to the ungated run, and done is held during stalls.
